// File: rtl/readout_sequencer.sv
// Register address generator for the POCI readout mux: decodes the command byte, then steps per data byte.
// Build option READOUT_SKIP_EMPTY_EN: read bursts skip channel blocks whose hit flag is clear.
module readout_sequencer #(
   parameter int CH_N = 8
) (
   input  logic            spi_clk,
   input  logic            full_rstn,
   input  logic            pico,
   input  logic [CH_N-1:0] ch_hit,
   output logic [6:0]      addr,
   output logic            rd_mode,
   output logic            byte_done,
   output logic [CH_N-1:0] ch_ack,
   output logic            burst_end
);

   localparam logic       ST_CMD    = 1'b0;
   localparam logic       ST_DATA   = 1'b1;
   localparam logic [6:0] SPI_LAST  = 7'd9;
   localparam logic [6:0] IDLE_ADDR = 7'd127;
   // Last register of the highest channel (66 for eight channels).
   localparam logic [6:0] MAP_LAST  = 7'(7 * CH_N + 10);

   logic            state_reg;
   logic [2:0]      bit_cnt_reg;
   logic [6:0]      cmd_shift_reg;
   logic [6:0]      addr_reg;
   logic [6:0]      addr_next;
   logic [6:0]      linear_next;
   logic            rd_mode_reg;
   logic            byte_done_reg;
   logic [CH_N-1:0] ch_ack_reg;
   logic [CH_N-1:0] is_last;
   logic            byte_end;

   assign byte_end    = (bit_cnt_reg == 3'd7);
   assign linear_next = (addr_reg < MAP_LAST) ? addr_reg + 7'd1 : IDLE_ADDR;

   genvar gi;
   generate
      for (gi = 0; gi < CH_N; gi++) begin : g_last
         localparam int LAST_I = (gi == 0) ? 17 : 18 + 7 * (gi - 1) + 6;
         assign is_last[gi] = (addr_reg == 7'(LAST_I));
      end
   endgenerate

`ifdef READOUT_SKIP_EMPTY_EN
   logic [6:0]      ch_base [CH_N];
   logic [CH_N-1:0] passed;
   logic [CH_N-1:0] eligible;
   logic [6:0]      jump_addr;
   logic [6:0]      skip_next;

   generate
      for (gi = 0; gi < CH_N; gi++) begin : g_skip
         localparam int BASE_I = (gi == 0) ? 10 : 18 + 7 * (gi - 1);
         localparam logic [CH_N-1:0] LOWER = CH_N'((64'd1 << gi) - 64'd1);
         assign ch_base[gi] = 7'(BASE_I);
         // Channel gi lies beyond the block whose last register is being read.
         assign passed[gi]  = |(is_last & LOWER);
      end
   endgenerate

   assign eligible = ch_hit & ((addr_reg == SPI_LAST) ? {CH_N{1'b1}} : passed);

   always_comb begin
      jump_addr = IDLE_ADDR;
      for (int j = CH_N - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            jump_addr = ch_base[j];
         end
      end
   end

   always_comb begin
      skip_next = linear_next;
      if ((addr_reg == SPI_LAST) || (|is_last)) begin
         skip_next = jump_addr;
      end
   end

   assign addr_next = rd_mode_reg ? skip_next : linear_next;
`else
   logic unused_hit;
   assign unused_hit = ^ch_hit;
   assign addr_next  = linear_next;
`endif

   always_ff @(posedge spi_clk or negedge full_rstn) begin
      if (!full_rstn) begin
         state_reg     <= ST_CMD;
         bit_cnt_reg   <= 3'd0;
         cmd_shift_reg <= 7'd0;
         addr_reg      <= 7'd0;
         rd_mode_reg   <= 1'b0;
         byte_done_reg <= 1'b0;
         ch_ack_reg    <= '0;
      end else begin
         bit_cnt_reg   <= bit_cnt_reg + 3'd1;
         byte_done_reg <= byte_end;
         ch_ack_reg    <= '0;
         if (state_reg == ST_CMD) begin
            cmd_shift_reg <= {cmd_shift_reg[5:0], pico};
            if (byte_end) begin
               rd_mode_reg <= cmd_shift_reg[6];
               addr_reg    <= {cmd_shift_reg[5:0], pico};
               state_reg   <= ST_DATA;
            end
         end else if (byte_end) begin
            addr_reg   <= addr_next;
            ch_ack_reg <= is_last & {CH_N{rd_mode_reg}};
         end
      end
   end

   assign addr      = addr_reg;
   assign rd_mode   = rd_mode_reg;
   assign byte_done = byte_done_reg;
   assign ch_ack    = ch_ack_reg;
   assign burst_end = (addr_reg == IDLE_ADDR);

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized self-checking bench for readout_sequencer against an address-map reference model.
module tb_readout_sequencer;

   logic       spi_clk   = 1'b0;
   logic       full_rstn = 1'b0;
   logic       pico      = 1'b0;
   logic [7:0] ch_hit    = 8'd0;
   logic [6:0] addr;
   logic       rd_mode;
   logic       byte_done;
   logic [7:0] ch_ack;
   logic       burst_end;

   int checks = 0;
   int errors = 0;
   int cur_addr;
   bit cur_rd;

`ifdef READOUT_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   always #5 spi_clk = ~spi_clk;

   readout_sequencer #(.CH_N(8)) dut (
      .spi_clk   (spi_clk),
      .full_rstn (full_rstn),
      .pico      (pico),
      .ch_hit    (ch_hit),
      .addr      (addr),
      .rd_mode   (rd_mode),
      .byte_done (byte_done),
      .ch_ack    (ch_ack),
      .burst_end (burst_end)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ch_base(input int k);
      return (k == 0) ? 10 : 18 + 7 * (k - 1);
   endfunction

   function automatic int ch_last(input int k);
      return (k == 0) ? 17 : ch_base(k) + 6;
   endfunction

   function automatic int first_hit_from(input int k0, input logic [7:0] hit);
      for (int k = k0; k < 8; k++) if (hit[k]) return ch_base(k);
      return 127;
   endfunction

   function automatic int model_next(input int a, input bit rd, input logic [7:0] hit);
      if (!rd || !SKIP) return (a < 66) ? a + 1 : 127;
      if (a <= 8) return a + 1;
      if (a == 9) return first_hit_from(0, hit);
      for (int k = 0; k < 8; k++) if (a == ch_last(k)) return first_hit_from(k + 1, hit);
      if (a <= 66) return a + 1;
      return 127;
   endfunction

   function automatic int model_ack(input int a, input bit rd);
      int r = 0;
      if (rd) for (int k = 0; k < 8; k++) if (a == ch_last(k)) r = 1 << k;
      return r;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge spi_clk);
      pico = b;
      @(posedge spi_clk);
      #1;
   endtask

   task automatic apply_reset;
      @(negedge spi_clk);
      full_rstn = 1'b0;
      ch_hit    = 8'($urandom);
      #1;
      check_val("rst_addr", int'(addr), 0);
      check_val("rst_rd_mode", int'(rd_mode), 0);
      check_val("rst_byte_done", int'(byte_done), 0);
      check_val("rst_ch_ack", int'(ch_ack), 0);
      check_val("rst_burst_end", int'(burst_end), 0);
      repeat (2) @(negedge spi_clk);
      @(posedge spi_clk);
      #1 full_rstn = 1'b1;
   endtask

   task automatic send_cmd(input logic [7:0] cmd);
      for (int bi = 0; bi < 8; bi++) begin
         send_bit(cmd[7 - bi]);
         if (bi == 0) check_val("cmd_mid_done", int'(byte_done), 0);
      end
      cur_addr = int'(cmd[6:0]);
      cur_rd   = cmd[7];
      check_val("cmd_addr", int'(addr), cur_addr);
      check_val("cmd_rd_mode", int'(rd_mode), int'(cur_rd));
      check_val("cmd_byte_done", int'(byte_done), 1);
      check_val("cmd_ch_ack", int'(ch_ack), 0);
      check_val("cmd_burst_end", int'(burst_end), int'(cur_addr == 127));
   endtask

   task automatic send_data_byte(input logic [7:0] hit);
      int exp_addr;
      int exp_ack;
      for (int bi = 0; bi < 8; bi++) begin
         @(negedge spi_clk);
         pico = 1'($urandom);
         if (bi == 7) ch_hit = hit;
         @(posedge spi_clk);
         #1;
         if (bi == 0) begin
            check_val("mid_addr", int'(addr), cur_addr);
            check_val("mid_byte_done", int'(byte_done), 0);
            check_val("mid_ch_ack", int'(ch_ack), 0);
         end
      end
      exp_addr = model_next(cur_addr, cur_rd, hit);
      exp_ack  = model_ack(cur_addr, cur_rd);
      $display("byte: from %0d rd %0d hit %02h -> addr %0d ack %02h (exp %0d %02h)",
               cur_addr, cur_rd, hit, addr, ch_ack, exp_addr, exp_ack);
      check_val("data_addr", int'(addr), exp_addr);
      check_val("data_ch_ack", int'(ch_ack), exp_ack);
      check_val("data_byte_done", int'(byte_done), 1);
      check_val("data_burst_end", int'(burst_end), int'(exp_addr == 127));
      cur_addr = exp_addr;
   endtask

   task automatic run_txn(input logic [7:0] cmd, input int nbytes, input bit rand_hit,
                          input logic [7:0] hit_fixed);
      logic [7:0] h;
      apply_reset();
      send_cmd(cmd);
      for (int n = 0; n < nbytes; n++) begin
         h = rand_hit ? 8'($urandom & $urandom) : hit_fixed;
         send_data_byte(h);
      end
   endtask

   initial begin
      logic [7:0] cmd;

      // Reset and plain command decode.
      run_txn(8'h85, 0, 1'b0, 8'h00);

      // Read burst with channels 0 and 2 flagged.
      run_txn(8'h8A, 16, 1'b0, 8'b0000_0101);
      if (SKIP) check_val("skip_end_addr", int'(addr), 127);
      else check_val("lin_end_addr", int'(addr), 26);

      // Jump straight from the SPI block to channel 7.
      run_txn(8'h89, 9, 1'b0, 8'h80);

      // Write mode near the top of the map.
      run_txn(8'h40, 4, 1'b0, 8'hFF);
      check_val("wr_end_addr", int'(addr), 127);

      // Nine bytes from channel 0 with no hits.
      run_txn(8'h8A, 9, 1'b0, 8'h00);
      if (!SKIP) check_val("lin_ch1_addr", int'(addr), 19);

      // Abort three bits into the first data byte.
      apply_reset();
      send_cmd(8'h91);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom));
      #2 full_rstn = 1'b0;
      #1;
      check_val("abort_addr", int'(addr), 0);
      check_val("abort_rd_mode", int'(rd_mode), 0);
      check_val("abort_byte_done", int'(byte_done), 0);
      run_txn(8'h05, 2, 1'b1, 8'h00);

      // Abort during the last byte of channel 0: no acknowledge may appear.
      run_txn(8'h8A, 7, 1'b0, 8'hFF);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      #2 full_rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge spi_clk);
         #1 check_val("abort_no_ack", int'(ch_ack), 0);
      end

      // Randomized bursts.
      for (int t = 0; t < 30; t++) begin
         cmd[7]   = 1'($urandom_range(0, 3) != 0);
         cmd[6:0] = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 70)) : 7'($urandom);
         run_txn(cmd, $urandom_range(1, 20), 1'b1, 8'h00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Generates the 7-bit register address that drives the POCI readout multiplexer during an SPI transaction. It decodes the 8-bit command byte, then advances the address once per completed data byte. In read bursts it skips channel blocks whose hit flag is clear and pulses a per-channel acknowledge when a channel's last register has been read. It sits between the SPI shift logic and the readout mux, clocked by `spi_clk` and reset whenever chip-select drops.

## Interface
- `CH_N`, default 8: number of timestamp channels. The address map below is fixed for 8.
- `spi_clk`: input, 1 bit. SPI clock; all state updates on its rising edge.
- `full_rstn`: input, 1 bit. Reset, asynchronous, active-low. Driven as cs & rstn, so each transaction starts from reset.
- `pico`: input, 1 bit. Serial data from the controller, MSB first.
- `ch_hit`: input, CH_N bits. Channel k holds an unread timestamp. Already synchronous to `spi_clk`.
- `addr`: output, 7 bits. Current register address, registered.
- `rd_mode`: output, 1 bit. Latched R/W bit of the command (1 = read).
- `byte_done`: output, 1 bit. One-cycle pulse on the edge that completes any byte, command or data.
- `ch_ack`: output, CH_N bits. One-cycle pulse when the last register of channel k completes in read mode.
- `burst_end`: output, 1 bit. Level. High while `addr` = 127.

## Operation
- Address map:
  - SPI registers: 0–9.
  - Channel 0: 10–17.
  - Channel k (k = 1..7): base 18+7(k−1), last base+6. Last addresses are 24, 31, 38, 45, 52, 59, 66.
  - 127: the idle address; the mux outputs 0 there.
- FSM states:
  - CMD: shift 8 bits. On bit 7, latch `rd_mode` from cmd[7] and load `addr` from cmd[6:0], then go to DATA.
  - DATA: count 8 bits per byte. On bit 7, `addr` takes the value next(addr). Stay in DATA until reset.
- `bit_cnt` is 3 bits and wraps 7→0 on every byte.
- next(a), evaluated in read mode:
  - a in 0–8 → a+1.
  - a = 9 → base of the lowest channel with hit; 127 if none.
  - a inside a channel block, not last → a+1.
  - a = last of channel k → base of the lowest j > k with `ch_hit[j]`=1; 127 if none.
  - a in 67–127 → 127 (saturate).
- Write mode (`rd_mode`=0): next(a) = a+1 for a < 66, otherwise 127. No skipping, no `ch_ack`.
- The start address from the command is used as-is, even if that channel's hit flag is clear. Skipping applies only on increments.
- `ch_hit` is sampled on the same edge that computes next(a).
- `ch_ack[k]` pulses on the edge that completes the byte at channel k's last address. It pulses only if `rd_mode`=1, and independent of `ch_hit[k]`.

## Timing
- Reset values:
  - `addr` = 0, `rd_mode` = 0, `byte_done` = 0, `ch_ack` = 0, `burst_end` = 0.
  - FSM in CMD, `bit_cnt` = 0.
- Latency: `addr` changes on the same rising edge that samples bit 7 of a byte. The mux registers `addr` on the following edge, so the new byte is served from the next bit period.
- `byte_done` and `ch_ack` are high for exactly one `spi_clk` cycle after that edge.
- Reset mid-byte (cs deassertion): everything returns to reset values immediately. No `ch_ack` is issued for a partially read channel.
- Simultaneous events:
  - `ch_hit` changing on the skip edge: the new value is used.
  - `ch_ack[k]` and a jump to channel j occur on the same edge.
- Once at 127, `addr` stays there. `byte_done` keeps pulsing every 8 bits.

## Configuration
- `READOUT_SKIP_EMPTY_EN` defined: read-mode next(a) skips channels whose hit flag is clear, as specified above.
- Undefined: read mode uses the write-mode linear rule, 0→66 then 127, and `ch_hit` is ignored. `ch_ack[k]` still pulses at each channel's last address.

## Test plan
- Reset: hold `full_rstn`=0 → `addr`=0, `ch_ack`=0, `byte_done`=0. Release; send cmd 0x85 → after the 8th edge `addr`=5, `rd_mode`=1.
- Skip (macro on): cmd 0x8A, `ch_hit`=8'b0000_0101, 16 data bytes →
  - `addr` runs 10..17, with `ch_ack[0]` on byte 8.
  - `addr` then jumps to 25 and runs to 31, with `ch_ack[2]` on byte 15.
  - `addr` then goes to 127 and `burst_end`=1.
- SPI to channel: cmd 0x89, `ch_hit`=8'h80 → after the first data byte `addr`=60; `ch_ack[7]` after byte 8; then `addr`=127.
- Write mode: cmd 0x40 (addr 64), 4 bytes → `addr` sequence 65, 66, 127, 127; `ch_ack` stays 0 throughout.
- Mid-byte abort: cmd 0x91, deassert cs after 3 data bits → `addr`=0, state CMD. The next command parses cleanly.
- Macro off: cmd 0x8A, `ch_hit`=0, 9 bytes → `addr` 11..17 then 18 and 19; `ch_ack[0]` on byte 8.
